mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-to-writeback pipeline stage of the RISC-V core, directly downstream of the memory-stage control decode.
- Registers the MEM-stage instruction, PC, ALU result and memory-region enables.
- Selects the synchronous read word from DMEM, BIOS or IO, then aligns and sign/zero-extends it.
- Produces the register-file write port and the forwarding value `wb_wdata`; holds load data stable across stalls.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word loaded into the WB register on reset and flush (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  freeze WB register (hold current instruction).
- flush  input  1  replace incoming instruction with bubble; lower priority than stall.
- mem_inst  input  32  instruction in MEM stage.
- mem_pc  input  32  PC of MEM-stage instruction.
- mem_alu  input  32  ALU result; also the load/store address.
- mem_dmem_en  input  1  load targets DMEM (from MEM control).
- mem_bios_en  input  1  load targets BIOS.
- mem_io_en  input  1  load targets IO.
- dmem_dout  input  32  DMEM read word; valid the cycle after address.
- bios_dout  input  32  BIOS read word; same timing.
- io_dout  input  32  IO read word; same timing.
- wb_inst  output  32  registered instruction (hazard detection upstream).
- wb_valid  output  1  WB slot holds a real instruction.
- wb_rd  output  5  destination register = wb_inst[11:7].
- wb_we  output  1  register-file write enable.
- wb_wdata  output  32  writeback / forwarding data.
- wb_misaligned  output  1  load address misaligned for its size.

Behaviour:
- Reset (rst_n=0, async):
  - wb_inst=NOP_INST, wb_valid=0, pc/alu/enables=0, hold state FRESH, hold word 0.
  - Resulting outputs: wb_rd=0, wb_we=0, wb_wdata=0, wb_misaligned=0.
- Register update priority per edge:
  - stall=1: hold all fields.
  - else flush=1: load NOP_INST, valid=0, enables=0.
  - else: capture the mem_* inputs, valid=1.
- Latency: combinational MEM inputs appear on WB outputs exactly one cycle later.
- Read-data hold FSM (2 states):
  - FRESH: raw word = region mux of the *_dout inputs; on an edge with stall=1, latch raw word into hold register and go to HELD.
  - HELD: raw word = hold register; remain while stall=1; go to FRESH on the first edge with stall=0.
  - Flush or reset forces FRESH.
  - Region mux: io > bios > dmem priority if several enables are set; all zero gives raw word 0.
- Load alignment (opcode LOAD), offset = wb_alu[1:0]:
  - LB: byte[offset], sign-extended.
  - LBU: byte[offset], zero-extended.
  - LH: half[offset[1]], sign-extended.
  - LHU: half[offset[1]], zero-extended.
  - LW: full word.
  - Misaligned: LH/LHU with offset[0]=1, or LW with offset≠0, sets wb_misaligned=1. Data uses the truncated offset as above; wb_we is unchanged.
  - Undefined funct3: wb_wdata=0, wb_we=1.
- Writeback select:
  - LOAD: aligned data.
  - JAL/JALR: wb_pc+4, modulo 2^32 (wrap at 32'hFFFF_FFFC gives 0).
  - All other opcodes: wb_alu.
- wb_we = wb_valid AND opcode not in {STORE, BRANCH, CSR} AND wb_rd≠0.
- wb_misaligned=0 for non-loads and invalid slots.
- Reset asserted mid-stall: HELD state and hold word are discarded immediately.

Decomposition:
- Shared include (opcode.vh / control_sel.vh): opcode, funct3 load encodings, NOP constant, writeback-select codes.
- Sub-module load_align: combinational; inputs raw word, funct3, offset; outputs data and misaligned flag.

Test Plan:
- Reset with rst_n low mid-cycle -> outputs immediately wb_inst=32'h13, wb_we=0, wb_wdata=0, wb_valid=0.
- LB at addr 0x1000_0003, dmem_dout=0x80FF_1234 -> next cycle wb_wdata=0xFFFF_FF80, wb_we=1, wb_misaligned=0.
- LHU at addr 0x1000_0002, same word -> wb_wdata=0x0000_80FF; LW at 0x1000_0002 -> wb_misaligned=1.
- Load enters WB, stall=1 for 3 cycles while dmem_dout changes to 0xDEAD_BEEF -> wb_wdata stays the first-cycle word (0x1234_5678) throughout; after release the next instruction writes back normally.
- JAL with pc 0xFFFF_FFFC, rd=x1 -> wb_wdata=0x0000_0000, wb_we=1; same with rd=x0 -> wb_we=0.
- flush=1 and stall=1 together on a store-to-add transition -> WB holds prior instruction; flush alone -> wb_valid=0, wb_we=0, wb_inst=32'h13.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: opcodes, load funct3 encodings,
// the bubble instruction, writeback-select codes and the read-data hold states.
package mem_wb_stage_pkg;

  // addi x0,x0,0 - the canonical bubble
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_CSR    = 7'b111_0011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic {
    HOLD_FRESH = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_e;

  // Which value an instruction writes back, decided by opcode alone
  function automatic wb_sel_e wb_sel_of(input logic [6:0] opcode);
    wb_sel_e sel;
    case (opcode)
      OPC_LOAD: sel = WB_SEL_MEM;
      OPC_JAL:  sel = WB_SEL_PC4;
      OPC_JALR: sel = WB_SEL_PC4;
      default:  sel = WB_SEL_ALU;
    endcase
    return sel;
  endfunction

  // Stores, branches and CSR/system ops never write the register file
  function automatic logic writes_rd(input logic [6:0] opcode);
    logic w;
    case (opcode)
      OPC_STORE:  w = 1'b0;
      OPC_BRANCH: w = 1'b0;
      OPC_CSR:    w = 1'b0;
      default:    w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit read word,
// extends it per funct3 and flags size-misaligned addresses.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select; misaligned halves/words still use the truncated offset
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (offset_i)
      2'd0:    byte_s = raw_i[7:0];
      2'd1:    byte_s = raw_i[15:8];
      2'd2:    byte_s = raw_i[23:16];
      2'd3:    byte_s = raw_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      half_s = raw_i[31:16];
    end else begin
      half_s = raw_i[15:0];
    end
  end

  // Extension and misalignment per load size; unknown funct3 yields zero
  always_comb begin
    data_o       = 32'h0000_0000;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU: data_o = {24'h00_0000, byte_s};
      F3_LH: begin
        data_o       = {{16{half_s[15]}}, half_s};
        misaligned_o = offset_i[0];
      end
      F3_LHU: begin
        data_o       = {16'h0000, half_s};
        misaligned_o = offset_i[0];
      end
      F3_LW: begin
        data_o       = raw_i;
        misaligned_o = (offset_i != 2'd0);
      end
      default: begin
        data_o       = 32'h0000_0000;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register plus load-data selection, alignment, writeback
// mux and a hold FSM that keeps load data stable while the stage is stalled.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_alu,
  input  logic        mem_dmem_en,
  input  logic        mem_bios_en,
  input  logic        mem_io_en,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic [31:0] io_dout,
  output logic [31:0] wb_inst,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_wdata,
  output logic        wb_misaligned
);

  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic        dmem_en_q, dmem_en_d;
  logic        bios_en_q, bios_en_d;
  logic        io_en_q, io_en_d;
  hold_state_e hold_state_q, hold_state_d;
  logic [31:0] hold_word_q, hold_word_d;

  logic [31:0] fresh_word_s;
  logic [31:0] raw_word_s;
  logic [31:0] align_data_s;
  logic        align_mis_s;
  logic [6:0]  opcode_s;
  logic        is_load_s;

  // Pipeline register next state: stall holds, flush inserts a bubble
  always_comb begin
    inst_d    = inst_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    dmem_en_d = dmem_en_q;
    bios_en_d = bios_en_q;
    io_en_d   = io_en_q;
    if (stall) begin
      inst_d = inst_q;
    end else if (flush) begin
      inst_d    = NOP_INST;
      valid_d   = 1'b0;
      pc_d      = 32'h0000_0000;
      alu_d     = 32'h0000_0000;
      dmem_en_d = 1'b0;
      bios_en_d = 1'b0;
      io_en_d   = 1'b0;
    end else begin
      inst_d    = mem_inst;
      valid_d   = 1'b1;
      pc_d      = mem_pc;
      alu_d     = mem_alu;
      dmem_en_d = mem_dmem_en;
      bios_en_d = mem_bios_en;
      io_en_d   = mem_io_en;
    end
  end

  // Read-region mux for the word belonging to the instruction now in WB
  always_comb begin
    fresh_word_s = 32'h0000_0000;
    if (io_en_q) begin
      fresh_word_s = io_dout;
    end else if (bios_en_q) begin
      fresh_word_s = bios_dout;
    end else if (dmem_en_q) begin
      fresh_word_s = dmem_dout;
    end else begin
      fresh_word_s = 32'h0000_0000;
    end
  end

  // Hold FSM: capture the word on the first stalled edge, release when stall drops
  always_comb begin
    hold_state_d = hold_state_q;
    hold_word_d  = hold_word_q;
    case (hold_state_q)
      HOLD_FRESH: begin
        if (stall) begin
          hold_state_d = HOLD_HELD;
          hold_word_d  = fresh_word_s;
        end else begin
          hold_state_d = HOLD_FRESH;
        end
      end
      HOLD_HELD: begin
        if (stall) begin
          hold_state_d = HOLD_HELD;
        end else begin
          hold_state_d = HOLD_FRESH;
        end
      end
      default: hold_state_d = HOLD_FRESH;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q       <= NOP_INST;
      valid_q      <= 1'b0;
      pc_q         <= 32'h0000_0000;
      alu_q        <= 32'h0000_0000;
      dmem_en_q    <= 1'b0;
      bios_en_q    <= 1'b0;
      io_en_q      <= 1'b0;
      hold_state_q <= HOLD_FRESH;
      hold_word_q  <= 32'h0000_0000;
    end else begin
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      dmem_en_q    <= dmem_en_d;
      bios_en_q    <= bios_en_d;
      io_en_q      <= io_en_d;
      hold_state_q <= hold_state_d;
      hold_word_q  <= hold_word_d;
    end
  end

  // Word fed to alignment: the held copy while stalled, otherwise live data
  always_comb begin
    raw_word_s = fresh_word_s;
    if (hold_state_q == HOLD_HELD) begin
      raw_word_s = hold_word_q;
    end else begin
      raw_word_s = fresh_word_s;
    end
  end

  mem_wb_stage_load_align u_align (
    .raw_i        (raw_word_s),
    .funct3_i     (inst_q[14:12]),
    .offset_i     (alu_q[1:0]),
    .data_o       (align_data_s),
    .misaligned_o (align_mis_s)
  );

  assign opcode_s  = inst_q[6:0];
  assign is_load_s = (opcode_s == OPC_LOAD);

  assign wb_inst  = inst_q;
  assign wb_valid = valid_q;
  assign wb_rd    = inst_q[11:7];

  // Writeback data select and write-enable / misalignment qualification
  always_comb begin
    wb_wdata = alu_q;
    case (wb_sel_of(opcode_s))
      WB_SEL_MEM: wb_wdata = align_data_s;
      WB_SEL_PC4: wb_wdata = pc_q + 32'd4;
      WB_SEL_ALU: wb_wdata = alu_q;
      default:    wb_wdata = alu_q;
    endcase
    wb_we         = valid_q & writes_rd(opcode_s) & (inst_q[11:7] != 5'd0);
    wb_misaligned = valid_q & is_load_s & align_mis_s;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load alignment, region priority,
// stall hold, JAL link wrap, flush/stall priority.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] mem_inst = 32'h0000_0013;
  logic [31:0] mem_pc = 32'h0;
  logic [31:0] mem_alu = 32'h0;
  logic        mem_dmem_en = 1'b0;
  logic        mem_bios_en = 1'b0;
  logic        mem_io_en = 1'b0;
  logic [31:0] dmem_dout = 32'h0;
  logic [31:0] bios_dout = 32'h0;
  logic [31:0] io_dout = 32'h0;
  logic [31:0] wb_inst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        wb_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] LOAD = 7'b000_0011;
  localparam logic [6:0] STORE = 7'b010_0011;
  localparam logic [6:0] OPIMM = 7'b001_0011;
  localparam logic [6:0] OP = 7'b011_0011;
  localparam logic [6:0] JAL = 7'b110_1111;
  localparam logic [6:0] JALR = 7'b110_0111;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_inst(mem_inst), .mem_pc(mem_pc), .mem_alu(mem_alu),
    .mem_dmem_en(mem_dmem_en), .mem_bios_en(mem_bios_en), .mem_io_en(mem_io_en),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout), .io_dout(io_dout),
    .wb_inst(wb_inst), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_wdata(wb_wdata), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0_0000, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic dm, input logic bi, input logic io);
    mem_inst = inst; mem_pc = pc; mem_alu = alu;
    mem_dmem_en = dm; mem_bios_en = bi; mem_io_en = io;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    set_mem(mk(OPIMM, 3'b000, 5'd5), 32'h100, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_wdata !== 32'h77) begin n_err++; $display("FAIL pre_reset_addi: valid=%b wdata=%h expected 1/00000077", wb_valid, wb_wdata); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (wb_inst !== 32'h0000_0013) begin n_err++; $display("FAIL reset_inst: got %h expected 00000013", wb_inst); end
    n_cmp++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_ctl: valid=%b we=%b rd=%0d expected 0/0/0", wb_valid, wb_we, wb_rd); end
    n_cmp++; if (wb_wdata !== 32'h0 || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_data: wdata=%h mis=%b expected 0/0", wb_wdata, wb_misaligned); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_align();
    set_mem(mk(LOAD, 3'b000, 5'd5), 32'h200, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
    tick(); dmem_dout = 32'h80FF_1234; #1;
    n_cmp++; if (wb_wdata !== 32'hFFFF_FF80 || wb_we !== 1'b1 || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL lb_sext: wdata=%h we=%b mis=%b expected ffffff80/1/0", wb_wdata, wb_we, wb_misaligned); end
    n_cmp++; if (wb_rd !== 5'd5 || wb_valid !== 1'b1) begin n_err++; $display("FAIL lb_rd: rd=%0d valid=%b expected 5/1", wb_rd, wb_valid); end
    set_mem(mk(LOAD, 3'b101, 5'd6), 32'h204, 32'h1000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0000_80FF || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL lhu: wdata=%h mis=%b expected 000080ff/0", wb_wdata, wb_misaligned); end
    set_mem(mk(LOAD, 3'b010, 5'd6), 32'h208, 32'h1000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_misaligned !== 1'b1 || wb_wdata !== 32'h80FF_1234 || wb_we !== 1'b1) begin n_err++; $display("FAIL lw_mis: mis=%b wdata=%h we=%b expected 1/80ff1234/1", wb_misaligned, wb_wdata, wb_we); end
    set_mem(mk(LOAD, 3'b001, 5'd6), 32'h20C, 32'h1000_0001, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_misaligned !== 1'b1 || wb_wdata !== 32'h0000_1234) begin n_err++; $display("FAIL lh_mis: mis=%b wdata=%h expected 1/00001234", wb_misaligned, wb_wdata); end
    set_mem(mk(LOAD, 3'b100, 5'd6), 32'h210, 32'h1000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0000_00FF) begin n_err++; $display("FAIL lbu: wdata=%h expected 000000ff", wb_wdata); end
    set_mem(mk(LOAD, 3'b011, 5'd6), 32'h214, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0 || wb_we !== 1'b1 || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL undef_f3: wdata=%h we=%b mis=%b expected 0/1/0", wb_wdata, wb_we, wb_misaligned); end
  endtask

  task automatic test_region_priority();
    dmem_dout = 32'h0000_0011; bios_dout = 32'h0000_0022; io_dout = 32'h0000_0033;
    set_mem(mk(LOAD, 3'b010, 5'd8), 32'h300, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (wb_wdata !== 32'h33) begin n_err++; $display("FAIL prio_io: got %h expected 00000033", wb_wdata); end
    set_mem(mk(LOAD, 3'b010, 5'd8), 32'h304, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h22) begin n_err++; $display("FAIL prio_bios: got %h expected 00000022", wb_wdata); end
    set_mem(mk(LOAD, 3'b010, 5'd8), 32'h308, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0) begin n_err++; $display("FAIL prio_none: got %h expected 00000000", wb_wdata); end
  endtask

  task automatic test_stall_hold();
    set_mem(mk(LOAD, 3'b010, 5'd7), 32'h400, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
    tick(); dmem_dout = 32'h1234_5678; #1;
    n_cmp++; if (wb_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL stall_first: got %h expected 12345678", wb_wdata); end
    stall = 1'b1;
    set_mem(mk(LOAD, 3'b010, 5'd9), 32'h404, 32'h1000_0004, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); dmem_dout = 32'hDEAD_BEEF; #1;
      n_cmp++; if (wb_wdata !== 32'h1234_5678 || wb_inst !== mk(LOAD, 3'b010, 5'd7)) begin n_err++; $display("FAIL stall_hold%0d: wdata=%h inst=%h expected 12345678/%h", i, wb_wdata, wb_inst, mk(LOAD, 3'b010, 5'd7)); end
    end
    stall = 1'b0;
    tick(); dmem_dout = 32'hCAFE_F00D; #1;
    n_cmp++; if (wb_wdata !== 32'hCAFE_F00D || wb_rd !== 5'd9 || wb_we !== 1'b1) begin n_err++; $display("FAIL stall_release: wdata=%h rd=%0d we=%b expected cafef00d/9/1", wb_wdata, wb_rd, wb_we); end
  endtask

  task automatic test_reset_mid_stall();
    set_mem(mk(LOAD, 3'b010, 5'd4), 32'h500, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
    dmem_dout = 32'hAAAA_5555;
    tick();
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (wb_wdata !== 32'h0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_stall: wdata=%h valid=%b expected 0/0", wb_wdata, wb_valid); end
    stall = 1'b0;
    tick(); rst_n = 1'b1;
    set_mem(mk(LOAD, 3'b010, 5'd4), 32'h504, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
    tick(); dmem_dout = 32'h0BAD_F00D; #1;
    n_cmp++; if (wb_wdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rst_hold_discard: got %h expected 0badf00d", wb_wdata); end
  endtask

  task automatic test_jal();
    set_mem(mk(JAL, 3'b000, 5'd1), 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0 || wb_we !== 1'b1) begin n_err++; $display("FAIL jal_wrap: wdata=%h we=%b expected 0/1", wb_wdata, wb_we); end
    set_mem(mk(JAL, 3'b000, 5'd0), 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL jal_x0: we=%b expected 0", wb_we); end
    set_mem(mk(JALR, 3'b000, 5'd2), 32'h0000_0100, 32'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_wdata !== 32'h0000_0104 || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL jalr_link: wdata=%h mis=%b expected 00000104/0", wb_wdata, wb_misaligned); end
  endtask

  task automatic test_flush();
    set_mem(mk(STORE, 3'b010, 5'd3), 32'h600, 32'h1000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (wb_we !== 1'b0 || wb_valid !== 1'b1 || wb_misaligned !== 1'b0) begin n_err++; $display("FAIL store_we: we=%b valid=%b mis=%b expected 0/1/0", wb_we, wb_valid, wb_misaligned); end
    set_mem(mk(OP, 3'b000, 5'd3), 32'h604, 32'h0000_0042, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    n_cmp++; if (wb_inst !== mk(STORE, 3'b010, 5'd3) || wb_valid !== 1'b1) begin n_err++; $display("FAIL stall_over_flush: inst=%h valid=%b expected %h/1", wb_inst, wb_valid, mk(STORE, 3'b010, 5'd3)); end
    stall = 1'b0;
    tick();
    n_cmp++; if (wb_inst !== 32'h0000_0013 || wb_valid !== 1'b0 || wb_we !== 1'b0) begin n_err++; $display("FAIL flush_bubble: inst=%h valid=%b we=%b expected 00000013/0/0", wb_inst, wb_valid, wb_we); end
    flush = 1'b0;
    tick();
    n_cmp++; if (wb_wdata !== 32'h42 || wb_we !== 1'b1 || wb_rd !== 5'd3) begin n_err++; $display("FAIL post_flush_add: wdata=%h we=%b rd=%0d expected 42/1/3", wb_wdata, wb_we, wb_rd); end
  endtask

  initial begin
    test_reset();
    test_load_align();
    test_region_priority();
    test_stall_hold();
    test_reset_mid_stall();
    test_jal();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
